glyph_render: RTL
=================

GLYPH_RENDER -- requirements
Module: glyph_render

Interface
REQ-001 SHALL have parameters: NUM_DIGITS, default 3, number of glyph cells in a row (1..8).
REQ-002 SHALL have parameters: CHAR_W, default 32, glyph width in pixels (power of 2, 8..64).
REQ-003 SHALL have parameters: CHAR_H, default 32, glyph height in rows (power of 2, 8..64).
REQ-004 SHALL have parameters: X0 = 100 (left edge of digit 0), PITCH = 100 (digit k left edge = X0 + k*PITCH, PITCH >= CHAR_W), Y0 = 100 (top row).
REQ-005 SHALL have ports: clk_gr  in  1  pixel clock, one index step per cycle.
REQ-006 SHALL have ports: rst_n_gr  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: h_index, v_index  in  10  current scan position.
REQ-008 SHALL have ports: line_buffer  in  CHAR_W  font row, bit CHAR_W-1 = leftmost pixel.
REQ-009 SHALL have ports: digit_sel  out  3  cell index of request, 0 = leftmost.
REQ-010 SHALL have ports: line_sel  out  log2(CHAR_H)  glyph row of request.
REQ-011 SHALL have ports: en_mem  out  1  font memory read enable.
REQ-012 SHALL have ports: pixel_out  out  1  rendered pixel; pixel_active  out  1  pixel_out lies inside a glyph cell.

Function
REQ-013 SHALL treat (h,v) as in-window when Y0 <= v < Y0+CHAR_H and, for some k < NUM_DIGITS, X0+k*PITCH <= h < X0+k*PITCH+CHAR_W.
REQ-014 SHALL run stage 1 at every edge: en_mem <= in-window; when in-window, digit_sel <= k, line_sel <= v-Y0, col_s1 <= h-X0-k*PITCH.
REQ-015 SHALL hold digit_sel and line_sel at their last values when not in-window.
REQ-016 SHALL depend on a font memory that returns line_buffer for (digit_sel, line_sel) one cycle after en_mem is high.
REQ-017 SHALL run stage 2: col_s2 <= col_s1, vld_s2 <= en_mem.
REQ-018 SHALL run stage 3: pixel_active <= vld_s2; pixel_out <= vld_s2 & line_buffer[CHAR_W-1-col_s2].
REQ-019 SHALL have fixed latency: index sampled at edge n appears on pixel_out/pixel_active after edge n+2, with no bubbles or lead offsets.
REQ-020 SHALL force pixel_out = 0 and pixel_active = 0 outside windows, including h/v beyond the visible area.
REQ-021 SHALL handle PITCH == CHAR_W: cells abut, digit_sel steps k -> k+1 on consecutive cycles, en_mem stays high, and no pixel is dropped.
REQ-022 SHALL treat last column/row (col = CHAR_W-1, line = CHAR_H-1) as fully rendered; the next index outside the window deasserts en_mem on the following edge.
REQ-023 SHALL use all-unsigned arithmetic; subtraction is evaluated only inside the window, so no wrap-around is possible.

Reset
REQ-024 SHALL, while rst_n_gr = 0, immediately clear digit_sel, line_sel, en_mem, pixel_out, pixel_active, col_s1, col_s2, vld_s2 and the blink counter to 0.
REQ-025 SHALL, on reset mid-frame, flush the pipeline; the first valid pixel after release is the one sampled at the first edge after release, appearing 2 edges later.

Configuration
REQ-026 SHALL, with macro GLYPH_RENDER_BLINK_EN defined, add input blink_mask [NUM_DIGITS-1:0] and an 6-bit frame counter.
REQ-027 SHALL, with GLYPH_RENDER_BLINK_EN defined, increment the frame counter on each edge sampling h_index == 0 && v_index == 0.
REQ-028 SHALL, with GLYPH_RENDER_BLINK_EN defined and counter bit 5 = 1, force pixel_out to 0 for cells with blink_mask[k] = 1, while en_mem and pixel_active still follow REQ-014 to REQ-018.
REQ-029 SHALL carry the blink decision through the pipeline aligned with col_s2.
REQ-030 SHALL, with GLYPH_RENDER_BLINK_EN undefined, have no blink_mask port and no counter, and render all cells always.

Verification
REQ-031 SHALL cover: defaults, v=100, h=97..133, line_buffer=32'h80000001 -> en_mem high after edges sampling h=100..131; pixel_out=1 for h=100 and h=131 only (2 edges later); digit_sel=0, line_sel=0.
REQ-032 SHALL cover: v=131, h=300 -> digit_sel=2, line_sel=31; v=132 -> en_mem=0, pixel_active=0.
REQ-033 SHALL cover: CHAR_W=8, PITCH=8, NUM_DIGITS=4, sweep h=X0..X0+31 -> digit_sel 0,1,2,3 each held 8 cycles, en_mem continuously high.
REQ-034 SHALL cover: rst_n_gr low at v=110, h=215 for 3 cycles -> all outputs 0 asynchronously; the pixel for h=220 appears 2 edges after sampling.
REQ-035 SHALL cover: GLYPH_RENDER_BLINK_EN, blink_mask=3'b010, 64 frames -> digit 1 blank during frames 32..63, digits 0/2 unaffected, en_mem pattern unchanged.
REQ-036 SHALL cover: h=640..799, v=480..524 -> pixel_out, pixel_active, en_mem stay 0.

Source files
------------

// File: rtl/glyph_render_if.sv
// rtl/glyph_render_if.sv - scan index, font memory and pixel signals of glyph_render
// master drives the scan position and font data, slave is the renderer.
interface glyph_render_if #(
  parameter int CHAR_W = 32,
  parameter int CHAR_H = 32
);
  logic [9:0]                h_index;
  logic [9:0]                v_index;
  logic [CHAR_W-1:0]         line_buffer;
  logic [2:0]                digit_sel;
  logic [$clog2(CHAR_H)-1:0] line_sel;
  logic                      en_mem;
  logic                      pixel_out;
  logic                      pixel_active;

  modport master (
    output h_index, v_index, line_buffer,
    input  digit_sel, line_sel, en_mem, pixel_out, pixel_active
  );

  modport slave (
    input  h_index, v_index, line_buffer,
    output digit_sel, line_sel, en_mem, pixel_out, pixel_active
  );
endinterface

// File: rtl/glyph_render.sv
// rtl/glyph_render.sv - three-stage glyph row renderer with font memory request port
// Optional blinking cells are enabled by defining GLYPH_RENDER_BLINK_EN.
module glyph_render #(
  parameter int NUM_DIGITS = 3,
  parameter int CHAR_W     = 32,
  parameter int CHAR_H     = 32,
  parameter int X0         = 100,
  parameter int PITCH      = 100,
  parameter int Y0         = 100
) (
  input  logic                  clk_gr,
  input  logic                  rst_n_gr,
`ifdef GLYPH_RENDER_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  glyph_render_if.slave         gr
);

  localparam int CW_B = $clog2(CHAR_W);
  localparam int CH_B = $clog2(CHAR_H);

  logic [31:0]     h_ext;
  logic [31:0]     v_ext;
  logic [31:0]     left;
  logic            in_win;
  logic [2:0]      hit_k;
  logic [CW_B-1:0] hit_col;
  logic [CH_B-1:0] hit_line;
  logic [CW_B-1:0] col_s1;
  logic [CW_B-1:0] col_s2;
  logic            vld_s2;
  logic            blank_s2;
`ifdef GLYPH_RENDER_BLINK_EN
  logic            hit_blink;
  logic [5:0]      frame_cnt;
  logic            blink_s1;
  logic            blink_s2;
`endif

  // Subtractions only feed registers when in_win, so they never wrap into use.
  always_comb begin
    h_ext    = {22'd0, gr.h_index};
    v_ext    = {22'd0, gr.v_index};
    left     = '0;
    in_win   = 1'b0;
    hit_k    = '0;
    hit_col  = '0;
    hit_line = CH_B'(v_ext - 32'(Y0));
`ifdef GLYPH_RENDER_BLINK_EN
    hit_blink = 1'b0;
`endif
    if (v_ext >= 32'(Y0) && v_ext < 32'(Y0 + CHAR_H)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        left = 32'(X0 + k * PITCH);
        if (h_ext >= left && h_ext < left + 32'(CHAR_W)) begin
          in_win  = 1'b1;
          hit_k   = 3'(k);
          hit_col = CW_B'(h_ext - left);
`ifdef GLYPH_RENDER_BLINK_EN
          hit_blink = blink_mask[k];
`endif
        end
      end
    end
  end

  // CHAR_W is a power of two, so CHAR_W-1-col is simply ~col.
  always_ff @(posedge clk_gr or negedge rst_n_gr) begin
    if (!rst_n_gr) begin
      gr.en_mem       <= 1'b0;
      gr.digit_sel    <= '0;
      gr.line_sel     <= '0;
      gr.pixel_out    <= 1'b0;
      gr.pixel_active <= 1'b0;
      col_s1          <= '0;
      col_s2          <= '0;
      vld_s2          <= 1'b0;
    end else begin
      gr.en_mem <= in_win;
      if (in_win) begin
        gr.digit_sel <= hit_k;
        gr.line_sel  <= hit_line;
        col_s1       <= hit_col;
      end
      col_s2          <= col_s1;
      vld_s2          <= gr.en_mem;
      gr.pixel_active <= vld_s2;
      gr.pixel_out    <= vld_s2 & gr.line_buffer[~col_s2] & ~blank_s2;
    end
  end

`ifdef GLYPH_RENDER_BLINK_EN
  // The blink decision rides alongside the column so it lands on the same pixel.
  always_ff @(posedge clk_gr or negedge rst_n_gr) begin
    if (!rst_n_gr) begin
      frame_cnt <= '0;
      blink_s1  <= 1'b0;
      blink_s2  <= 1'b0;
    end else begin
      if (gr.h_index == 10'd0 && gr.v_index == 10'd0) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
      if (in_win) begin
        blink_s1 <= frame_cnt[5] & hit_blink;
      end
      blink_s2 <= blink_s1;
    end
  end
  assign blank_s2 = blink_s2;
`else
  assign blank_s2 = 1'b0;
`endif

endmodule
